// File: rtl/branch_redirect_ctrl_pkg.sv
// rtl/branch_redirect_ctrl_pkg.sv - shared types and constants for the branch redirect controller
package branch_redirect_ctrl_pkg;

  // Redirect FSM: IDLE handles branches directly, PENDING holds a target while fetch is stalled
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } redir_state_e;

  localparam int XLEN_DEFAULT   = 32;
  // A taken branch resolved in EX squashes the IF/ID and ID/EX contents
  localparam int BRANCH_BUBBLES = 2;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// rtl/branch_redirect_ctrl_sat_counter.sv - saturating up-counter for performance events
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise step by one and stick at all-ones
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - PC select, flush and stall control for EX-stage branch redirects
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_branch_taken,
  input  logic [XLEN-1:0]  ex_pc_branch,
  input  logic             if_stall,
  input  logic             load_use_hazard,
  output logic             pc_sel,
  output logic [XLEN-1:0]  pc_redirect,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             redirect_busy,
  output logic [CNT_W-1:0] taken_count
);

  redir_state_e    state_q;
  redir_state_e    state_d;
  logic [XLEN-1:0] pend_target_q;
  logic [XLEN-1:0] pend_target_d;
  logic            take;
  logic            count_inc;

  // A branch only counts when EX holds a real instruction
  assign take = ex_valid & ex_branch_taken;

  // Next state and control outputs; everything is forced low while reset is held
  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    pc_sel        = 1'b0;
    pc_redirect   = '0;
    stall_pc      = 1'b0;
    stall_ifid    = 1'b0;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    redirect_busy = 1'b0;
    count_inc     = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (take) begin
            // Redirect beats a load-use stall: the dependent instruction is squashed
            count_inc   = 1'b1;
            pc_redirect = ex_pc_branch;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            if (if_stall) begin
              pend_target_d = ex_pc_branch;
              state_d       = PENDING;
            end else begin
              pc_sel = 1'b1;
            end
          end else if (load_use_hazard) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
          end
        end
        PENDING: begin
          // EX and ID are squashed here, so only fetch readiness matters
          redirect_busy = 1'b1;
          pc_redirect   = pend_target_q;
          flush_ifid    = 1'b1;
          flush_idex    = 1'b1;
          if (if_stall) begin
            stall_pc = 1'b1;
          end else begin
            pc_sel  = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and held target; reset aborts any pending redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_taken_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (1'b0),
    .inc_i  (count_inc),
    .count_o(taken_count)
  );

endmodule
